// File: rtl/dot_scan_controller.sv
// Frame-scan controller: walks row/col selects over a programmed rectangle,
// samples the dot sequencer once per dot and emits an on-time/dead-time drive pulse.
module dot_scan_controller #(
  parameter int MEM_LENGTH         = 48,
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int TIMER_WIDTH        = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop_en,
  input  logic                          scan_mode,
  input  logic [MEM_ADDRESS_LENGTH-1:0] row_count,
  input  logic [MEM_ADDRESS_LENGTH-1:0] col_count,
  input  logic [TIMER_WIDTH-1:0]        on_time,
  input  logic [TIMER_WIDTH-1:0]        dead_time,
  input  logic                          firing_bit,
  input  logic                          firing_data,
  output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
  output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
  output logic                          row_col_select,
  output logic                          drive_en,
  output logic                          drive_data,
  output logic                          busy,
  output logic                          frame_done
);
  localparam int AW = MEM_ADDRESS_LENGTH;
  localparam int TW = TIMER_WIDTH;
  localparam logic [AW-1:0] MAX_CNT = AW'(MEM_LENGTH);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [TW-1:0] ONE_T   = TW'(1);
  localparam logic [TW-1:0] ZERO_T  = '0;

  typedef enum logic [1:0] {IDLE, SETTLE, FIRE, DEAD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, row_d, col_q, col_d;
  logic [AW-1:0] rows_q, rows_d, cols_q, cols_d;
  logic [TW-1:0] tmr_q, tmr_d, on_q, on_d, dead_q, dead_d;
  logic          bit_q, bit_d, data_q, data_d;
  logic          loop_q, loop_d, mode_q, mode_d;
  logic          drive_en_q, drive_data_q, busy_q, frame_done_q, rcs_q;
  logic          adv, last_d, fin_d, done_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    tmr_d   = tmr_q;
    on_d    = on_q;
    dead_d  = dead_q;
    bit_d   = bit_q;
    data_d  = data_q;
    loop_d  = loop_q;
    mode_d  = mode_q;
    adv     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && row_count != '0 && col_count != '0) begin
          rows_d  = (row_count > MAX_CNT) ? MAX_CNT : row_count;
          cols_d  = (col_count > MAX_CNT) ? MAX_CNT : col_count;
          on_d    = on_time;
          dead_d  = dead_time;
          loop_d  = loop_en;
          mode_d  = scan_mode;
          row_d   = '0;
          col_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        bit_d  = firing_bit;
        data_d = firing_data;
        if (on_q != ZERO_T) begin
          state_d = FIRE;
          tmr_d   = on_q;
        end else if (dead_q != ZERO_T) begin
          state_d = DEAD;
          tmr_d   = dead_q;
        end else begin
          adv = 1'b1;
        end
      end
      FIRE: begin
        if (tmr_q > ONE_T) begin
          tmr_d = tmr_q - ONE_T;
        end else if (dead_q != ZERO_T) begin
          state_d = DEAD;
          tmr_d   = dead_q;
        end else begin
          adv = 1'b1;
        end
      end
      DEAD: begin
        if (tmr_q > ONE_T) tmr_d = tmr_q - ONE_T;
        else               adv   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Advance to the next dot; the next SETTLE starts directly, no extra state.
    if (adv) begin
      tmr_d = '0;
      if (col_q == cols_q - ONE_A) begin
        col_d = '0;
        if (row_q == rows_q - ONE_A) begin
          row_d   = '0;
          state_d = loop_q ? SETTLE : IDLE;
        end else begin
          row_d   = row_q + ONE_A;
          state_d = SETTLE;
        end
      end else begin
        col_d   = col_q + ONE_A;
        state_d = SETTLE;
      end
    end

    if (stop) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      tmr_d   = '0;
      bit_d   = 1'b0;
      data_d  = 1'b0;
    end

    // frame_done marks the final cycle of the final dot of the upcoming state.
    last_d = (row_d == rows_d - ONE_A) && (col_d == cols_d - ONE_A);
    fin_d  = ((state_d == SETTLE) && on_d == ZERO_T && dead_d == ZERO_T) ||
             ((state_d == FIRE) && tmr_d == ONE_T && dead_d == ZERO_T) ||
             ((state_d == DEAD) && tmr_d == ONE_T);
    done_d = (state_d != IDLE) && last_d && fin_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      tmr_q        <= '0;
      on_q         <= '0;
      dead_q       <= '0;
      bit_q        <= 1'b0;
      data_q       <= 1'b0;
      loop_q       <= 1'b0;
      mode_q       <= 1'b0;
      drive_en_q   <= 1'b0;
      drive_data_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rcs_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      tmr_q        <= tmr_d;
      on_q         <= on_d;
      dead_q       <= dead_d;
      bit_q        <= bit_d;
      data_q       <= data_d;
      loop_q       <= loop_d;
      mode_q       <= mode_d;
      drive_en_q   <= (state_d == FIRE) && bit_d;
      drive_data_q <= (state_d == FIRE) && data_d;
      busy_q       <= (state_d != IDLE);
      frame_done_q <= done_d;
      rcs_q        <= (state_d != IDLE) && mode_d;
    end
  end

  assign row_select     = row_q;
  assign col_select     = col_q;
  assign row_col_select = rcs_q;
  assign drive_en       = drive_en_q;
  assign drive_data     = drive_data_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;

endmodule
